// File: rtl/sh7604_pkg.sv
// Shared types for the SH7604 data-bus arbiter: bus-owner encoding and the
// per-master request bundle routed through the owner mux.
package sh7604_pkg;

  typedef enum logic [1:0] {
    DBO_NONE = 2'd0,
    DBO_CPU  = 2'd1,
    DBO_DMA  = 2'd2,
    DBO_EXT  = 2'd3
  } DBusOwner_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] dat;
    logic [3:0]  ba;
    logic        we;
    logic        req;
    logic        lock;
    logic        burst;
  } DBusReq_t;

  localparam int unsigned DBUS_REQ_W = $bits(DBusReq_t);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sh7604_dbus_mux.sv
// Owner-driven 2:1 select of the CPU or DMAC request bundle onto the BSC data bus.
module sh7604_dbus_mux
  import sh7604_pkg::*;
(
  input  DBusOwner_t own,
  input  DBusReq_t   cpu,
  input  DBusReq_t   dma,
  output DBusReq_t   bus
);

  // Idle and external ownership both park the bus at all-zero.
  always_comb begin
    bus = {DBUS_REQ_W{1'b0}};
    case (own)
      DBO_CPU: bus = cpu;
      DBO_DMA: bus = dma;
      default: bus = {DBUS_REQ_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/sh7604_dbus_arb.sv
// SH7604 data-bus arbiter: external master > DMAC > CPU, LOCK/BURST hold, BRLS_N/BGR_N release.
// Optional CPU fairness against long DMAC runs is enabled by defining SH7604_DBUS_ARB_FAIR_EN.
module sh7604_dbus_arb
  import sh7604_pkg::*;
#(
  parameter int unsigned DMA_MAX_RUN = 32'd16
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_r,
  input  logic        ce_f,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_do,
  input  logic [3:0]  cpu_ba,
  input  logic        cpu_we,
  input  logic        cpu_req,
  input  logic        cpu_lock,
  input  logic        cpu_burst,
  output logic [31:0] cpu_di,
  output logic        cpu_wait,
  input  logic [31:0] dma_a,
  input  logic [31:0] dma_do,
  input  logic [3:0]  dma_ba,
  input  logic        dma_we,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic        dma_burst,
  output logic [31:0] dma_di,
  output logic        dma_wait,
  output logic        dma_ack,
  output logic [31:0] bus_a,
  output logic [31:0] bus_do,
  output logic [3:0]  bus_ba,
  output logic        bus_we,
  output logic        bus_req,
  output logic        bus_lock,
  output logic        bus_burst,
  input  logic [31:0] bus_di,
  input  logic        bus_wait,
  input  logic        brls_n,
  output logic        bgr_n
);

  DBusOwner_t own_q, own_d;
  logic       bgr_n_q, bgr_n_d;
  logic       done_free_q, done_free_d;
  DBusReq_t   cpu_s, dma_s, bus_s;
  logic       done_s, done_free_now_s, idle_s, abandon_s, free_s, cpu_turn_s;

  assign cpu_s = '{a: cpu_a, dat: cpu_do, ba: cpu_ba, we: cpu_we,
                   req: cpu_req, lock: cpu_lock, burst: cpu_burst};
  assign dma_s = '{a: dma_a, dat: dma_do, ba: dma_ba, we: dma_we,
                   req: dma_req, lock: dma_lock, burst: dma_burst};

  sh7604_dbus_mux u_mux (
    .own (own_q),
    .cpu (cpu_s),
    .dma (dma_s),
    .bus (bus_s)
  );

  // bus_s is zero for NONE/EXT, so these terms only ever see the current owner.
  assign done_s          = bus_s.req & ~bus_wait;
  assign done_free_now_s = ce_f & done_s & ~bus_s.lock & ~bus_s.burst;
  assign idle_s          = ~bus_s.req & ~bus_s.lock & ~bus_s.burst;
  assign abandon_s       = ~bus_s.req & bus_wait;
  assign free_s          = (own_q == DBO_NONE) | done_free_q | done_free_now_s | idle_s | abandon_s;

`ifdef SH7604_DBUS_ARB_FAIR_EN
  logic [7:0] dma_run_q, dma_run_d;

  // DMAC run length: counts DMAC completions, cleared by a CPU completion.
  always_comb begin
    if (ce_f && done_s && (own_q == DBO_DMA)) begin
      dma_run_d = sat_inc8(dma_run_q);
    end else if (ce_f && done_s && (own_q == DBO_CPU)) begin
      dma_run_d = 8'd0;
    end else begin
      dma_run_d = dma_run_q;
    end
  end

  // Run-length counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_run_q <= 8'd0;
    end else begin
      dma_run_q <= dma_run_d;
    end
  end

  assign cpu_turn_s = cpu_req & ({24'd0, dma_run_q} >= DMA_MAX_RUN);
`else
  assign cpu_turn_s = 1'b0;
`endif

  // Next owner: EXT exits on BRLS_N release, otherwise re-arbitrate only while free.
  always_comb begin
    own_d       = own_q;
    bgr_n_d     = bgr_n_q;
    done_free_d = done_free_q | done_free_now_s;
    if (ce_r) begin
      done_free_d = 1'b0;
      if (own_q == DBO_EXT) begin
        if (brls_n) begin
          own_d   = DBO_NONE;
          bgr_n_d = 1'b1;
        end else begin
          own_d   = DBO_EXT;
          bgr_n_d = 1'b0;
        end
      end else if (free_s) begin
        if (!brls_n) begin
          own_d   = DBO_EXT;
          bgr_n_d = 1'b0;
        end else if (cpu_turn_s) begin
          own_d   = DBO_CPU;
          bgr_n_d = 1'b1;
        end else if (dma_req) begin
          own_d   = DBO_DMA;
          bgr_n_d = 1'b1;
        end else if (cpu_req) begin
          own_d   = DBO_CPU;
          bgr_n_d = 1'b1;
        end else begin
          own_d   = DBO_NONE;
          bgr_n_d = 1'b1;
        end
      end else begin
        own_d   = own_q;
        bgr_n_d = bgr_n_q;
      end
    end else begin
      own_d   = own_q;
      bgr_n_d = bgr_n_q;
    end
  end

  // Ownership, grant and completion-seen registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q       <= DBO_NONE;
      bgr_n_q     <= 1'b1;
      done_free_q <= 1'b0;
    end else begin
      own_q       <= own_d;
      bgr_n_q     <= bgr_n_d;
      done_free_q <= done_free_d;
    end
  end

  assign bus_a     = bus_s.a;
  assign bus_do    = bus_s.dat;
  assign bus_ba    = bus_s.ba;
  assign bus_we    = bus_s.we;
  assign bus_req   = bus_s.req;
  assign bus_lock  = bus_s.lock;
  assign bus_burst = bus_s.burst;
  assign bgr_n     = bgr_n_q;
  assign cpu_di    = bus_di;
  assign dma_di    = bus_di;
  assign cpu_wait  = (own_q == DBO_CPU) ? bus_wait : cpu_req;
  assign dma_wait  = (own_q == DBO_DMA) ? bus_wait : dma_req;
  assign dma_ack   = (own_q == DBO_DMA) & dma_req;

endmodule

// File: tb/tb_sh7604_dbus_arb.sv
// Directed table-driven bench for sh7604_dbus_arb; fairness sequence follows SH7604_DBUS_ARB_FAIR_EN.
module tb_sh7604_dbus_arb;
  import sh7604_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, ce_r, ce_f;
  logic [31:0] cpu_a, cpu_do, dma_a, dma_do, bus_di;
  logic [3:0]  cpu_ba, dma_ba;
  logic        cpu_we, cpu_req, cpu_lock, cpu_burst;
  logic        dma_we, dma_req, dma_lock, dma_burst;
  logic        bus_wait, brls_n;
  logic [31:0] cpu_di, dma_di, bus_a, bus_do;
  logic [3:0]  bus_ba;
  logic        cpu_wait, dma_wait, dma_ack, bus_we, bus_req, bus_lock, bus_burst, bgr_n;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sh7604_dbus_arb #(.DMA_MAX_RUN(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .ce_r(ce_r), .ce_f(ce_f),
    .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_ba(cpu_ba), .cpu_we(cpu_we),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_burst(cpu_burst),
    .cpu_di(cpu_di), .cpu_wait(cpu_wait),
    .dma_a(dma_a), .dma_do(dma_do), .dma_ba(dma_ba), .dma_we(dma_we),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_burst(dma_burst),
    .dma_di(dma_di), .dma_wait(dma_wait), .dma_ack(dma_ack),
    .bus_a(bus_a), .bus_do(bus_do), .bus_ba(bus_ba), .bus_we(bus_we),
    .bus_req(bus_req), .bus_lock(bus_lock), .bus_burst(bus_burst),
    .bus_di(bus_di), .bus_wait(bus_wait), .brls_n(brls_n), .bgr_n(bgr_n)
  );

  typedef struct {
    logic       f;
    logic       cr, cl, cb, dr, dl, db, bw, brl;
    DBusOwner_t own;
  } vec_t;

  localparam logic R = 1'b0;
  localparam logic F = 1'b1;
  localparam int NV = 47;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic f, input logic cr, input logic cl, input logic cb,
                              input logic dr, input logic dl, input logic db, input logic bw,
                              input logic brl, input DBusOwner_t own);
    vec_t v;
    v.f = f; v.cr = cr; v.cl = cl; v.cb = cb; v.dr = dr; v.dl = dl; v.db = db;
    v.bw = bw; v.brl = brl; v.own = own;
    return v;
  endfunction

  // Expected outputs follow from the expected owner and the current inputs.
  task automatic check(input string name, input DBusOwner_t own);
    logic [139:0] exp_v, act_v;
    logic        e_req, e_we, e_lock, e_burst;
    logic [3:0]  e_ba;
    logic [31:0] e_a, e_do;
    if (own == DBO_CPU) begin
      {e_req, e_we, e_lock, e_burst, e_ba, e_a, e_do} =
        {cpu_req, cpu_we, cpu_lock, cpu_burst, cpu_ba, cpu_a, cpu_do};
    end else if (own == DBO_DMA) begin
      {e_req, e_we, e_lock, e_burst, e_ba, e_a, e_do} =
        {dma_req, dma_we, dma_lock, dma_burst, dma_ba, dma_a, dma_do};
    end else begin
      {e_req, e_we, e_lock, e_burst, e_ba, e_a, e_do} = 72'd0;
    end
    exp_v = {e_req, e_we, e_lock, e_burst, e_ba, e_a, e_do, bus_di, bus_di,
             (own == DBO_CPU) ? bus_wait : cpu_req,
             (own == DBO_DMA) ? bus_wait : dma_req,
             (own == DBO_DMA) & dma_req,
             (own != DBO_EXT)};
    act_v = {bus_req, bus_we, bus_lock, bus_burst, bus_ba, bus_a, bus_do, cpu_di, dma_di,
             cpu_wait, dma_wait, dma_ack, bgr_n};
    n_checks++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s (owner %s): got %h expected %h", name, own.name(), act_v, exp_v);
    end
  endtask

  task automatic step(input logic f);
    ce_r = ~f;
    ce_f = f;
    @(posedge clk);
    #1;
    ce_r = 1'b0;
    ce_f = 1'b0;
  endtask

  task automatic drive(input logic cr, input logic cl, input logic cb, input logic dr,
                       input logic dl, input logic db, input logic bw, input logic brl);
    cpu_req = cr; cpu_lock = cl; cpu_burst = cb;
    dma_req = dr; dma_lock = dl; dma_burst = db;
    bus_wait = bw; brls_n = brl;
  endtask

  initial begin
    DBusOwner_t exp_own;
    rst_n = 1'b0; ce_r = 1'b0; ce_f = 1'b0;
    cpu_a = 32'h0600_0000; cpu_do = 32'h1111_2222; cpu_ba = 4'hF; cpu_we = 1'b0;
    dma_a = 32'h0C00_0040; dma_do = 32'h3333_4444; dma_ba = 4'h3; dma_we = 1'b1;
    bus_di = 32'h5A5A_0000;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // CPU read with two wait states, then CPU+DMA collision, TAS lock, burst+release, abandon
    tbl[0]  = mk(R,1,0,0,0,0,0,0,1,DBO_CPU);
    tbl[1]  = mk(F,1,0,0,0,0,0,1,1,DBO_CPU);
    tbl[2]  = mk(R,1,0,0,0,0,0,1,1,DBO_CPU);
    tbl[3]  = mk(F,1,0,0,0,0,0,1,1,DBO_CPU);
    tbl[4]  = mk(R,1,0,0,0,0,0,1,1,DBO_CPU);
    tbl[5]  = mk(F,1,0,0,0,0,0,0,1,DBO_CPU);
    tbl[6]  = mk(R,0,0,0,0,0,0,0,1,DBO_NONE);
    tbl[7]  = mk(R,1,0,0,1,0,0,0,1,DBO_DMA);
    tbl[8]  = mk(F,1,0,0,1,0,0,1,1,DBO_DMA);
    tbl[9]  = mk(R,1,0,0,1,0,0,1,1,DBO_DMA);
    tbl[10] = mk(F,1,0,0,1,0,0,0,1,DBO_DMA);
    tbl[11] = mk(R,1,0,0,0,0,0,0,1,DBO_CPU);
    tbl[12] = mk(F,1,0,0,0,0,0,0,1,DBO_CPU);
    tbl[13] = mk(R,0,0,0,0,0,0,0,1,DBO_NONE);
    tbl[14] = mk(R,1,1,0,0,0,0,0,1,DBO_CPU);
    tbl[15] = mk(F,1,1,0,1,0,0,0,1,DBO_CPU);
    tbl[16] = mk(R,0,1,0,1,0,0,0,1,DBO_CPU);
    tbl[17] = mk(F,0,1,0,1,0,0,0,1,DBO_CPU);
    tbl[18] = mk(R,1,1,0,1,0,0,0,1,DBO_CPU);
    tbl[19] = mk(F,1,1,0,1,0,0,1,1,DBO_CPU);
    tbl[20] = mk(R,1,1,0,1,0,0,1,1,DBO_CPU);
    tbl[21] = mk(F,1,0,0,1,0,0,0,1,DBO_CPU);
    tbl[22] = mk(R,0,0,0,1,0,0,0,1,DBO_DMA);
    tbl[23] = mk(F,0,0,0,1,0,0,0,1,DBO_DMA);
    tbl[24] = mk(R,0,0,0,0,0,0,0,1,DBO_NONE);
    tbl[25] = mk(R,0,0,0,1,0,1,0,1,DBO_DMA);
    tbl[26] = mk(F,0,0,0,1,0,1,0,1,DBO_DMA);
    tbl[27] = mk(R,0,0,0,1,0,1,0,0,DBO_DMA);
    tbl[28] = mk(F,0,0,0,1,0,1,0,0,DBO_DMA);
    tbl[29] = mk(R,0,0,0,1,0,1,0,0,DBO_DMA);
    tbl[30] = mk(F,0,0,0,1,0,1,0,0,DBO_DMA);
    tbl[31] = mk(R,0,0,0,1,0,1,0,0,DBO_DMA);
    tbl[32] = mk(F,0,0,0,1,0,0,0,0,DBO_DMA);
    tbl[33] = mk(R,0,0,0,0,0,0,0,0,DBO_EXT);
    tbl[34] = mk(F,1,0,0,0,0,0,0,0,DBO_EXT);
    tbl[35] = mk(R,1,0,0,0,0,0,0,0,DBO_EXT);
    tbl[36] = mk(F,1,0,0,0,0,0,0,1,DBO_EXT);
    tbl[37] = mk(R,1,0,0,0,0,0,0,1,DBO_NONE);
    tbl[38] = mk(F,1,0,0,0,0,0,0,1,DBO_NONE);
    tbl[39] = mk(R,1,0,0,0,0,0,0,1,DBO_CPU);
    tbl[40] = mk(F,1,0,0,0,0,0,0,1,DBO_CPU);
    tbl[41] = mk(R,0,0,0,0,0,0,0,1,DBO_NONE);
    tbl[42] = mk(R,0,0,0,1,0,0,0,1,DBO_DMA);
    tbl[43] = mk(F,0,0,0,1,0,0,1,1,DBO_DMA);
    tbl[44] = mk(R,1,0,0,0,0,0,1,1,DBO_CPU);
    tbl[45] = mk(F,1,0,0,0,0,0,0,1,DBO_CPU);
    tbl[46] = mk(R,0,0,0,0,0,0,0,1,DBO_NONE);

    #12;
    check("reset_state", DBO_NONE);
    #10;
    cpu_req = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].cr, tbl[i].cl, tbl[i].cb, tbl[i].dr, tbl[i].dl, tbl[i].db, tbl[i].bw, tbl[i].brl);
      bus_di = 32'hA500_0000 | i;
      step(tbl[i].f);
      check($sformatf("vec%0d", i), tbl[i].own);
    end

    // Constant CPU and DMA demand: fairness inserts one CPU slot after four DMA completions
    for (int k = 0; k < 9; k++) begin
`ifdef SH7604_DBUS_ARB_FAIR_EN
      exp_own = (k == 4) ? DBO_CPU : DBO_DMA;
`else
      exp_own = DBO_DMA;
`endif
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(R);
      check($sformatf("run_grant%0d", k), exp_own);
      step(F);
      check($sformatf("run_done%0d", k), exp_own);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(R);
    check("run_idle", DBO_NONE);

    // Asynchronous reset in the middle of a stalled DMA access
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(R);
    check("rst_dma_grant", DBO_DMA);
    bus_wait = 1'b1;
    step(F);
    check("rst_dma_wait", DBO_DMA);
    #2 rst_n = 1'b0;
    #1 check("rst_dma_abort", DBO_NONE);
    #2 rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while the external master holds the bus
    step(R);
    check("rst_ext_grant", DBO_EXT);
    #2 rst_n = 1'b0;
    #1 check("rst_ext_abort", DBO_NONE);
    brls_n = 1'b1;
    #2 rst_n = 1'b1;
    step(R);
    check("post_rst_idle", DBO_NONE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
